// File: rtl/shift_adr_sched.sv
// Steps the 11-tap window base address across one video line and presents one window per cycle.
// Latency: line_start in cycle N -> first window (ref_addr=0) valid in cycle N+1; one window per accepted cycle.
// Backpressure: while win_valid && !win_ready, ref_addr/max/win_last/tap_cnt hold exactly.
module shift_adr_sched #(
    parameter int AW   = 10,
    parameter int TAPS = 11,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          line_start,
    input  logic [AW-1:0] line_max,
    input  logic          win_ready,
    output logic [AW-1:0] ref_addr,   // window base address ("ref" is a reserved word)
    output logic [AW-1:0] max,
    output logic          win_valid,
    output logic          win_last,
    output logic [3:0]    tap_cnt,
    output logic          busy,
    output logic          line_done,
    output logic          overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ref_nxt, max_nxt;
    logic          ovr_nxt;
    logic [AW:0]   ref_ext, max_ext, ref_step, span;
    logic          hs;

    // Address arithmetic one bit wider than AW so ref+STEP never wraps at the top of the buffer.
    always_comb begin
        ref_ext  = {1'b0, ref_addr};
        max_ext  = {1'b0, max};
        ref_step = ref_ext + (AW+1)'(STEP);
        span     = max_ext - ref_ext + (AW+1)'(1);
    end

    // Window outputs decoded from state and the registered ref/max.
    always_comb begin
        win_valid = (state == RUN);
        busy      = (state == RUN);
        line_done = (state == DONE);
        win_last  = win_valid && (ref_step > max_ext);
        hs        = win_valid && win_ready;
        if (!win_valid)
            tap_cnt = 4'd0;
        else if (span > (AW+1)'(TAPS))
            tap_cnt = 4'(TAPS);
        else
            tap_cnt = span[3:0];
    end

    // Next-state logic: a new line_start always restarts the line, ahead of any advance or finish.
    always_comb begin
        state_nxt = state;
        ref_nxt   = ref_addr;
        max_nxt   = max;
        ovr_nxt   = overrun;
        case (state)
            IDLE, DONE: begin
                if (line_start) begin
                    state_nxt = RUN;
                    max_nxt   = line_max;
                    ref_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (line_start) begin
                    max_nxt = line_max;
                    ref_nxt = '0;
                    ovr_nxt = 1'b1;
                end else if (hs) begin
                    if (win_last)
                        state_nxt = DONE;
                    else
                        ref_nxt = ref_step[AW-1:0];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and address registers; reset aborts any line in flight without a line_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ref_addr <= '0;
            max      <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ref_addr <= ref_nxt;
            max      <= max_nxt;
            overrun  <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_shift_adr_sched.sv
// Bench for shift_adr_sched: window-list scoreboard for a STEP=1 instance plus literal checks,
// and a STEP=3 instance checked against hand-computed windows.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_shift_adr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_start = 1'b0;
    logic [9:0] line_max = '0;
    logic       win_ready = 1'b0;
    logic [9:0] ref_addr, max;
    logic       win_valid, win_last, busy, line_done, overrun;
    logic [3:0] tap_cnt;

    logic       ls2 = 1'b0;
    logic [9:0] lm2 = '0;
    logic       rdy2 = 1'b1;
    logic [9:0] ref2, max2;
    logic       val2, last2, busy2, done2, ovr2;
    logic [3:0] tap2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    shift_adr_sched #(.AW(10), .TAPS(11), .STEP(1)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .line_max(line_max),
        .win_ready(win_ready), .ref_addr(ref_addr), .max(max), .win_valid(win_valid),
        .win_last(win_last), .tap_cnt(tap_cnt), .busy(busy), .line_done(line_done),
        .overrun(overrun));

    shift_adr_sched #(.AW(10), .TAPS(11), .STEP(3)) dut3 (
        .clk(clk), .rst(rst), .line_start(ls2), .line_max(lm2),
        .win_ready(rdy2), .ref_addr(ref2), .max(max2), .win_valid(val2),
        .win_last(last2), .tap_cnt(tap2), .busy(busy2), .line_done(done2),
        .overrun(ovr2));

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: the list of windows still owed for the current line.
    int q[$];
    int mmax = 0;
    bit exp_done = 1'b0;
    bit exp_ovr = 1'b0;
    int acc_ref[$];
    int acc_tap[$];
    int acc_last[$];

    always @(negedge clk) begin
        int t;
        bit nd;
        chk("win_valid", win_valid, q.size() > 0);
        chk("busy", busy, q.size() > 0);
        chk("line_done", line_done, exp_done);
        chk("overrun", overrun, exp_ovr);
        if (q.size() > 0) begin
            t = mmax - q[0] + 1;
            if (t > 11) t = 11;
            chk("ref", ref_addr, q[0]);
            chk("max", max, mmax);
            chk("win_last", win_last, q.size() == 1);
            chk("tap_cnt", tap_cnt, t);
        end else begin
            chk("tap_idle", tap_cnt, 0);
            chk("last_idle", win_last, 0);
        end
        if (win_valid && win_ready) begin
            acc_ref.push_back(ref_addr);
            acc_tap.push_back(tap_cnt);
            acc_last.push_back(win_last);
        end
        // Advance the model to what the coming edge must produce.
        nd = 1'b0;
        if (rst) begin
            q.delete();
            exp_ovr = 1'b0;
        end else if (line_start) begin
            if (q.size() > 0) exp_ovr = 1'b1;
            q.delete();
            for (int r = 0; r <= int'(line_max); r++) q.push_back(r);
            mmax = line_max;
        end else if (q.size() > 0 && win_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) nd = 1'b1;
        end
        exp_done = nd;
    end

    int acc2_ref[$];
    int acc2_tap[$];
    int acc2_last[$];
    always @(negedge clk) begin
        if (val2 && rdy2) begin
            acc2_ref.push_back(ref2);
            acc2_tap.push_back(tap2);
            acc2_last.push_back(last2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_acc();
        acc_ref.delete();
        acc_tap.delete();
        acc_last.delete();
    endtask

    task automatic start_line(input int m);
        line_start = 1'b1;
        line_max   = 10'(m);
        tick();
        line_start = 1'b0;
        line_max   = 10'($urandom_range(0, 1023));
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rand_ready) win_ready = 1'($urandom_range(0, 1));
            tick();
            if (line_done) begin
                seen = 1'b1;
                break;
            end
        end
        win_ready = 1'b1;
        if (!seen) chk("line_done_timeout", 0, 1);
    endtask

    task automatic wait_ref(input int r);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (win_valid && ref_addr == 10'(r)) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) chk("ref_timeout", 0, 1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ref", ref_addr, 0);
        chk("rst_max", max, 0);
        chk("rst_valid", win_valid, 0);
        chk("rst_tap", tap_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;
        win_ready = 1'b1;
        tick();

        // Nominal line 0..20.
        clear_acc();
        start_line(20);
        chk("first_ref", ref_addr, 0);
        wait_done(100, 1'b0);
        chk("nom_count", acc_ref.size(), 21);
        chk("nom_tap0", acc_tap[0], 11);
        chk("nom_tap10", acc_tap[10], 11);
        chk("nom_tap11", acc_tap[11], 10);
        chk("nom_ref15", acc_ref[15], 15);
        chk("nom_tap15", acc_tap[15], 6);
        chk("nom_tap20", acc_tap[20], 1);
        chk("nom_last19", acc_last[19], 0);
        chk("nom_last20", acc_last[20], 1);
        tick();
        chk("nom_idle_busy", busy, 0);
        chk("nom_idle_done", line_done, 0);

        // Backpressure line 0..15: every ref accepted once, in order.
        clear_acc();
        start_line(15);
        wait_done(400, 1'b1);
        chk("bp_count", acc_ref.size(), 16);
        for (int i = 0; i < 16 && i < acc_ref.size(); i++) chk("bp_order", acc_ref[i], i);

        // Single-window line; next line starts in the DONE cycle.
        clear_acc();
        start_line(0);
        wait_done(20, 1'b0);
        chk("one_count", acc_ref.size(), 1);
        chk("one_tap", acc_tap[0], 1);
        chk("one_last", acc_last[0], 1);

        // Top of the buffer, started back-to-back with the line_done cycle.
        clear_acc();
        start_line(1023);
        wait_done(1100, 1'b0);
        chk("top_count", acc_ref.size(), 1024);
        chk("top_ref", acc_ref[acc_ref.size()-1], 1023);
        chk("top_tap", acc_tap[acc_tap.size()-1], 1);
        tick();

        // Overrun: restart at ref 7 of a 50 line with max 30.
        clear_acc();
        start_line(50);
        wait_ref(7);
        start_line(30);
        chk("ovr_ref", ref_addr, 0);
        chk("ovr_max", max, 30);
        chk("ovr_flag", overrun, 1);
        wait_done(100, 1'b0);
        chk("ovr_count", acc_ref.size(), 39);
        chk("ovr_ref8", acc_ref[8], 0);
        chk("ovr_lastref", acc_ref[acc_ref.size()-1], 30);
        tick();

        // Reset mid-line at ref 5.
        start_line(40);
        wait_ref(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", win_valid, 0);
        chk("mrst_ref", ref_addr, 0);
        chk("mrst_max", max, 0);
        chk("mrst_ovr", overrun, 0);
        chk("mrst_done", line_done, 0);
        clear_acc();
        start_line(12);
        wait_done(100, 1'b0);
        chk("post_rst_count", acc_ref.size(), 13);
        chk("post_rst_ovr", overrun, 0);

        // Stride 3 instance, line_max 10: refs 0,3,6,9 / taps 11,8,5,2.
        ls2 = 1'b1;
        lm2 = 10'd10;
        tick();
        ls2 = 1'b0;
        lm2 = 10'd0;
        for (int i = 0; i < 20 && !done2; i++) tick();
        chk("s3_done", done2, 1);
        chk("s3_count", acc2_ref.size(), 4);
        if (acc2_ref.size() == 4) begin
            chk("s3_ref1", acc2_ref[1], 3);
            chk("s3_ref3", acc2_ref[3], 9);
            chk("s3_tap0", acc2_tap[0], 11);
            chk("s3_tap1", acc2_tap[1], 8);
            chk("s3_tap2", acc2_tap[2], 5);
            chk("s3_tap3", acc2_tap[3], 2);
            chk("s3_last2", acc2_last[2], 0);
            chk("s3_last3", acc2_last[3], 1);
        end
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
